// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
//
// Registered, handshaked instruction decoder placed between IF/ID and ID/EX.
// Decodes the opcode/funct of the presented instruction into the ID/EX control
// bundle. Every control output comes from a flop.
//
// On top of decoding, the stage provides:
//   * downstream stall (hold everything) and flush (squash to a bubble),
//   * load-use hazard detection against the instruction now in ID/EX, which
//     inserts a bubble and leaves the instruction un-consumed,
//   * multi-cycle sequencing of SAD (opcode 101000), which occupies the stage
//     for SAD_CYCLES cycles,
//   * optional trapping of illegal opcodes.
//
// Parameters:
//   SAD_CYCLES  cycles a SAD occupies the stage (1..255)
//   CNT_W       SAD counter width, 2**CNT_W > SAD_CYCLES
//
// Configuration macro:
//   ILLEGAL_TRAP_EN  defined   : an accepted illegal opcode becomes a bubble
//                                and sets the sticky IllegalOp flag (cleared
//                                only by Rst).
//                    undefined : an illegal opcode passes as a NOP carrying its
//                                opcode on AluOp; IllegalOp is tied 0.
//
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-high reset
//   Instr, InstrValid   instruction from IF/ID and its valid
//   InstrReady          combinational; accept happens on Valid && Ready edge
//   Stall               freeze all registered state and outputs
//   Flush               squash the stage, abort any SAD in progress
//   ExMemRead, ExRt     MemR field and rt of the instruction in ID/EX
//   OutValid            control bundle holds a real instruction
//   AluOp .. SADSignal  registered ID/EX control bundle
//   HazardStall         a load-use bubble was inserted this cycle
//   SadBusy             a SAD is in progress
//   IllegalOp           sticky illegal-opcode flag (trap build only)
// -----------------------------------------------------------------------------
module decode_ctrl_pipe #(
   parameter int unsigned SAD_CYCLES = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] Instr,
   input  logic        InstrValid,
   output logic        InstrReady,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [1:0]  ExMemRead,
   input  logic [4:0]  ExRt,
   output logic        OutValid,
   output logic [5:0]  AluOp,
   output logic [1:0]  RegDst,
   output logic [1:0]  MemR,
   output logic [1:0]  MemW,
   output logic [1:0]  MemReg,
   output logic        RegW,
   output logic        Jump,
   output logic        ALUSrc,
   output logic        Branch,
   output logic        Reg1Signal,
   output logic        JALSig,
   output logic        SADMuxSel,
   output logic        SADSignal,
   output logic        HazardStall,
   output logic        SadBusy,
   output logic        IllegalOp
);

   typedef struct packed {
      logic [5:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_r;
      logic [1:0] mem_w;
      logic [1:0] mem_reg;
      logic       reg_w;
      logic       jump;
      logic       alu_src;
      logic       branch;
      logic       reg1_signal;
      logic       jal_sig;
      logic       sad_mux_sel;
      logic       sad_signal;
   } ctrl_t;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_SAD_BUSY = 1'b1
   } state_t;

   localparam logic [5:0]       OP_SAD   = 6'b101000;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               SAD_MULTI = (SAD_CYCLES > 1);

   // Registered state
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   ctrl_t            r_ctrl;
   logic             r_valid;
   logic             r_haz;
   logic             r_busy;

   // Next-state values
   state_t           w_nxt_state;
   logic [CNT_W-1:0] w_nxt_cnt;
   ctrl_t            w_nxt_ctrl;
   logic             w_nxt_valid;
   logic             w_nxt_haz;
   logic             w_nxt_busy;

   // Decode / handshake
   logic [5:0]       w_opcode;
   logic [5:0]       w_funct;
   ctrl_t            w_dec;
   logic             w_legal;
   logic             w_haz;
   logic             w_accept;

   assign w_opcode = Instr[31:26];
   assign w_funct  = Instr[5:0];

   // -------------------------------------------------------------------------
   // Opcode decode table
   // -------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_dec        = '0;
      w_dec.alu_op = w_opcode;
      w_legal      = 1'b1;
      case (w_opcode)
         6'b000000: begin
            w_dec.reg_w   = 1'b1;
            w_dec.mem_reg = 2'd1;
            if (w_funct == 6'b000000 || w_funct == 6'b000010) begin
               w_dec.alu_src     = 1'b1;
               w_dec.reg1_signal = 1'b1;
            end else if (w_funct == 6'b001000) begin
               // JR: no write-back, resolved through the branch path
               w_dec.reg_w   = 1'b0;
               w_dec.mem_reg = 2'd0;
               w_dec.reg_dst = 2'd2;
               w_dec.branch  = 1'b1;
               w_dec.jal_sig = 1'b1;
            end
         end
         6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            w_dec.branch = 1'b1;
         end
         6'b000010: begin
            w_dec.jump = 1'b1;
         end
         6'b000011: begin
            w_dec.reg_w   = 1'b1;
            w_dec.jump    = 1'b1;
            w_dec.reg_dst = 2'd2;
            w_dec.mem_reg = 2'd2;
         end
         6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
            w_dec.reg_w   = 1'b1;
            w_dec.reg_dst = 2'd1;
            w_dec.alu_src = 1'b1;
            w_dec.mem_reg = 2'd1;
         end
         6'b101011: begin
            w_dec.alu_src = 1'b1;
            w_dec.mem_w   = 2'd1;
         end
         6'b101001: begin
            w_dec.alu_src = 1'b1;
            w_dec.mem_w   = 2'd2;
         end
         6'b100011, 6'b100001, 6'b100000: begin
            w_dec.reg_w   = 1'b1;
            w_dec.reg_dst = 2'd1;
            w_dec.alu_src = 1'b1;
            case (w_opcode)
               6'b100011: w_dec.mem_r = 2'd1;
               6'b100001: w_dec.mem_r = 2'd2;
               default: begin
                  w_dec.mem_r      = 2'd3;
                  w_dec.sad_signal = 1'b1;
               end
            endcase
         end
         6'b101000: begin
            w_dec.mem_w       = 2'd3;
            w_dec.sad_mux_sel = 1'b1;
         end
         6'b011100: begin
            w_dec.reg_w   = 1'b1;
            w_dec.mem_reg = 2'd1;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Load-use hazard and handshake
   // -------------------------------------------------------------------------
   assign w_haz = InstrValid && (ExMemRead != 2'd0) && (ExRt != 5'd0) &&
                  ((ExRt == Instr[25:21]) || (ExRt == Instr[20:16]));

   assign InstrReady = !Rst && !Stall && !Flush && !w_haz && (r_state == S_IDLE);
   assign w_accept   = InstrValid && InstrReady;

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;
   logic w_nxt_illegal;
   logic w_unused;
   assign w_unused = ^Instr[15:6];
`else
   logic w_unused;
   assign w_unused = ^{Instr[15:6], w_legal};
`endif

   // -------------------------------------------------------------------------
   // Next-state / next-output logic (priority: Flush, Stall, SAD, hazard,
   // accept, idle bubble)
   // -------------------------------------------------------------------------
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_ctrl  = '0;
      w_nxt_valid = 1'b0;
      w_nxt_haz   = 1'b0;
      w_nxt_busy  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      w_nxt_illegal = r_illegal;
`endif

      if (Flush) begin
         // Squash overrides Stall and aborts a SAD in flight
         w_nxt_state = S_IDLE;
         w_nxt_cnt   = '0;
      end else if (Stall) begin
         w_nxt_ctrl  = r_ctrl;
         w_nxt_valid = r_valid;
         w_nxt_haz   = r_haz;
         w_nxt_busy  = r_busy;
      end else if (r_state == S_SAD_BUSY) begin
         // r_cnt holds the busy cycles still to come after the current one;
         // the stage leaves on the edge that finds it exhausted, so the SAD
         // occupies SAD_CYCLES cycles counting its accept output cycle.
         if (r_cnt == '0) begin
            w_nxt_state = S_IDLE;
         end else begin
            w_nxt_cnt              = r_cnt - CNT_ONE;
            w_nxt_busy             = 1'b1;
            w_nxt_ctrl.alu_op      = OP_SAD;
            w_nxt_ctrl.sad_mux_sel = 1'b1;
         end
      end else if (w_haz) begin
         // Bubble; the instruction stays in IF/ID and is retried
         w_nxt_haz = 1'b1;
      end else if (w_accept) begin
`ifdef ILLEGAL_TRAP_EN
         if (!w_legal) begin
            w_nxt_illegal = 1'b1;
         end else begin
`else
         begin
`endif
            w_nxt_ctrl  = w_dec;
            w_nxt_valid = 1'b1;
            if (w_opcode == OP_SAD && SAD_MULTI) begin
               w_nxt_state = S_SAD_BUSY;
               w_nxt_cnt   = CNT_LOAD;
               w_nxt_busy  = 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values of the others.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ctrl  <= '0;
         r_valid <= 1'b0;
         r_haz   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_ctrl  <= w_nxt_ctrl;
         r_valid <= w_nxt_valid;
         r_haz   <= w_nxt_haz;
         r_busy  <= w_nxt_busy;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   // Sticky: only Rst clears it, Flush leaves it set
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_nxt_illegal;
      end
   end
   assign IllegalOp = r_illegal;
`else
   assign IllegalOp = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Output mapping
   // -------------------------------------------------------------------------
   assign OutValid    = r_valid;
   assign AluOp       = r_ctrl.alu_op;
   assign RegDst      = r_ctrl.reg_dst;
   assign MemR        = r_ctrl.mem_r;
   assign MemW        = r_ctrl.mem_w;
   assign MemReg      = r_ctrl.mem_reg;
   assign RegW        = r_ctrl.reg_w;
   assign Jump        = r_ctrl.jump;
   assign ALUSrc      = r_ctrl.alu_src;
   assign Branch      = r_ctrl.branch;
   assign Reg1Signal  = r_ctrl.reg1_signal;
   assign JALSig      = r_ctrl.jal_sig;
   assign SADMuxSel   = r_ctrl.sad_mux_sel;
   assign SADSignal   = r_ctrl.sad_signal;
   assign HazardStall = r_haz;
   assign SadBusy     = r_busy;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_pipe
//
// Directed bench for decode_ctrl_pipe (SAD_CYCLES = 4). Expected control
// bundles are hand-written constants pushed into a scoreboard queue whenever
// an instruction is offered for acceptance; a monitor pops and compares each
// freshly produced OutValid bundle. Stall, flush, hazard and SAD status are
// checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

   logic        Clk;
   logic        Rst;
   logic [31:0] Instr;
   logic        InstrValid;
   logic        InstrReady;
   logic        Stall;
   logic        Flush;
   logic [1:0]  ExMemRead;
   logic [4:0]  ExRt;
   logic        OutValid;
   logic [5:0]  AluOp;
   logic [1:0]  RegDst, MemR, MemW, MemReg;
   logic        RegW, Jump, ALUSrc, Branch, Reg1Signal, JALSig, SADMuxSel, SADSignal;
   logic        HazardStall, SadBusy, IllegalOp;

   decode_ctrl_pipe #(
      .SAD_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Instr       (Instr),
      .InstrValid  (InstrValid),
      .InstrReady  (InstrReady),
      .Stall       (Stall),
      .Flush       (Flush),
      .ExMemRead   (ExMemRead),
      .ExRt        (ExRt),
      .OutValid    (OutValid),
      .AluOp       (AluOp),
      .RegDst      (RegDst),
      .MemR        (MemR),
      .MemW        (MemW),
      .MemReg      (MemReg),
      .RegW        (RegW),
      .Jump        (Jump),
      .ALUSrc      (ALUSrc),
      .Branch      (Branch),
      .Reg1Signal  (Reg1Signal),
      .JALSig      (JALSig),
      .SADMuxSel   (SADMuxSel),
      .SADSignal   (SADSignal),
      .HazardStall (HazardStall),
      .SadBusy     (SadBusy),
      .IllegalOp   (IllegalOp)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {AluOp, RegDst, MemR, MemW, MemReg, RegW, Jump, ALUSrc, Branch,
   //  Reg1Signal, JALSig, SADMuxSel, SADSignal}
   logic [21:0] w_bundle;
   assign w_bundle = {AluOp, RegDst, MemR, MemW, MemReg, RegW, Jump, ALUSrc,
                      Branch, Reg1Signal, JALSig, SADMuxSel, SADSignal};

   // flags = {RegW, Jump, ALUSrc, Branch, Reg1Signal, JALSig, SADMuxSel, SADSignal}
   function automatic logic [21:0] mk(input logic [5:0] alu, input logic [1:0] rd,
                                      input logic [1:0] mr, input logic [1:0] mw,
                                      input logic [1:0] mg, input logic [7:0] flags);
      return {alu, rd, mr, mw, mg, flags};
   endfunction

   localparam logic [21:0] E_LW   = mk(6'b100011, 2'd1, 2'd1, 2'd0, 2'd0, 8'b1010_0000);
   localparam logic [21:0] E_SW   = mk(6'b101011, 2'd0, 2'd0, 2'd1, 2'd0, 8'b0010_0000);
   localparam logic [21:0] E_ADDI = mk(6'b001000, 2'd1, 2'd0, 2'd0, 2'd1, 8'b1010_0000);
   localparam logic [21:0] E_BEQ  = mk(6'b000100, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0001_0000);
   localparam logic [21:0] E_J    = mk(6'b000010, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0100_0000);
   localparam logic [21:0] E_JR   = mk(6'b000000, 2'd2, 2'd0, 2'd0, 2'd0, 8'b0001_0100);
   localparam logic [21:0] E_SLL  = mk(6'b000000, 2'd0, 2'd0, 2'd0, 2'd1, 8'b1010_1000);
   localparam logic [21:0] E_ADD  = mk(6'b000000, 2'd0, 2'd0, 2'd0, 2'd1, 8'b1000_0000);
   localparam logic [21:0] E_LH   = mk(6'b100001, 2'd1, 2'd2, 2'd0, 2'd0, 8'b1010_0000);
   localparam logic [21:0] E_LSAD = mk(6'b100000, 2'd1, 2'd3, 2'd0, 2'd0, 8'b1010_0001);
   localparam logic [21:0] E_SH   = mk(6'b101001, 2'd0, 2'd0, 2'd2, 2'd0, 8'b0010_0000);
   localparam logic [21:0] E_MUL  = mk(6'b011100, 2'd0, 2'd0, 2'd0, 2'd1, 8'b1000_0000);
   localparam logic [21:0] E_BLTZ = mk(6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0001_0000);
   localparam logic [21:0] E_SAD  = mk(6'b101000, 2'd0, 2'd0, 2'd3, 2'd0, 8'b0000_0010);
   localparam logic [21:0] E_SADB = mk(6'b101000, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0000_0010);
   localparam logic [21:0] E_JAL  = mk(6'b000011, 2'd2, 2'd0, 2'd0, 2'd2, 8'b1100_0000);
`ifndef ILLEGAL_TRAP_EN
   localparam logic [21:0] E_ILL  = mk(6'b111111, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0000_0000);
`endif

   localparam logic [31:0] I_ADDI = 32'h2008_000A;
   localparam logic [31:0] I_ADD  = 32'h0109_5020;
   localparam logic [31:0] I_SLL  = 32'h0008_4080;
   localparam logic [31:0] I_SAD  = 32'hA000_0000;

   logic [31:0] v_instr [13] = '{
      32'h8C08_0004, 32'hAC09_0008, I_ADDI,        32'h1109_0003,
      32'h0800_0010, 32'h03E0_0008, I_SLL,         I_ADD,
      32'h8408_0000, 32'h8008_0000, 32'hA408_0000, 32'h7000_0000,
      32'h0400_0000};
   logic [21:0] v_exp [13] = '{
      E_LW,  E_SW,   E_ADDI, E_BEQ,
      E_J,   E_JR,   E_SLL,  E_ADD,
      E_LH,  E_LSAD, E_SH,   E_MUL,
      E_BLTZ};

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [21:0] sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic check_busy(input string name);
      check({name, "_bundle"}, 32'(w_bundle), 32'(E_SADB));
      check({name, "_busy"},   32'(SadBusy),  32'd1);
      check({name, "_ov"},     32'(OutValid), 32'd0);
   endtask

   // Monitor: compare each bundle produced by an unstalled edge
   initial begin
      logic        e_stall;
      logic        e_rst;
      logic [21:0] exp;
      forever begin
         @(posedge Clk);
         e_stall = Stall;
         e_rst   = Rst;
         #1;
         if (!e_rst && !Rst && !e_stall && OutValid === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_outvalid", 32'(OutValid), 32'd0);
            end else begin
               exp = sb_q.pop_front();
               check("sb_bundle", 32'(w_bundle), 32'(exp));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst        = 1'b1;
      Instr      = '0;
      InstrValid = 1'b0;
      Stall      = 1'b0;
      Flush      = 1'b0;
      ExMemRead  = '0;
      ExRt       = '0;

      // Reset state
      step();
      step();
      check("rst_outvalid", 32'(OutValid),    32'd0);
      check("rst_bundle",   32'(w_bundle),    32'd0);
      check("rst_hazard",   32'(HazardStall), 32'd0);
      check("rst_sadbusy",  32'(SadBusy),     32'd0);
      check("rst_illegal",  32'(IllegalOp),   32'd0);
      check("rst_ready",    32'(InstrReady),  32'd0);
      Rst = 1'b0;
      #1;
      check("idle_ready", 32'(InstrReady), 32'd1);

      // Back-to-back decode stream, one instruction per cycle
      for (int i = 0; i < 13; i++) begin
         Instr      = v_instr[i];
         InstrValid = 1'b1;
         sb_q.push_back(v_exp[i]);
         #1;
         check("stream_ready", 32'(InstrReady), 32'd1);
         step();
      end
      InstrValid = 1'b0;
      step();
      check("idle_bubble_ov", 32'(OutValid), 32'd0);

      // Load-use hazard on rs
      Instr      = I_ADD;
      InstrValid = 1'b1;
      ExMemRead  = 2'd1;
      ExRt       = 5'd8;
      #1;
      check("haz_rs_ready", 32'(InstrReady), 32'd0);
      step();
      check("haz_rs_flag",   32'(HazardStall), 32'd1);
      check("haz_rs_ov",     32'(OutValid),    32'd0);
      check("haz_rs_bundle", 32'(w_bundle),    32'd0);
      ExMemRead = 2'd0;
      sb_q.push_back(E_ADD);
      #1;
      check("haz_clear_ready", 32'(InstrReady), 32'd1);
      step();
      check("haz_clear_flag", 32'(HazardStall), 32'd0);
      // Hazard on rt
      ExMemRead = 2'd3;
      ExRt      = 5'd9;
      #1;
      check("haz_rt_ready", 32'(InstrReady), 32'd0);
      step();
      check("haz_rt_flag", 32'(HazardStall), 32'd1);
      // ExRt = 0 never hazards, even when it matches rs
      Instr     = I_SLL;
      ExMemRead = 2'd1;
      ExRt      = 5'd0;
      sb_q.push_back(E_SLL);
      #1;
      check("haz_r0_ready", 32'(InstrReady), 32'd1);
      step();
      check("haz_r0_flag", 32'(HazardStall), 32'd0);
      InstrValid = 1'b0;
      ExMemRead  = 2'd0;
      step();

      // SAD: 4-cycle occupancy, stretched by one stall cycle
      Instr      = I_SAD;
      InstrValid = 1'b1;
      sb_q.push_back(E_SAD);
      step();
      Instr = I_ADDI;
      #1;
      check("sad_c0_busy",  32'(SadBusy),    32'd1);
      check("sad_c0_ready", 32'(InstrReady), 32'd0);
      step();
      check_busy("sad_c1");
      check("sad_c1_ready", 32'(InstrReady), 32'd0);
      Stall = 1'b1;
      step();
      check_busy("sad_stall");
      Stall = 1'b0;
      #1;
      check("sad_stall_ready", 32'(InstrReady), 32'd0);
      step();
      check_busy("sad_c2");
      check("sad_c2_ready", 32'(InstrReady), 32'd0);
      step();
      check_busy("sad_c3");
      check("sad_c3_ready", 32'(InstrReady), 32'd0);
      step();
      check("sad_done_busy",   32'(SadBusy),  32'd0);
      check("sad_done_ov",     32'(OutValid), 32'd0);
      check("sad_done_bundle", 32'(w_bundle), 32'd0);
      sb_q.push_back(E_ADDI);
      #1;
      check("sad_done_ready", 32'(InstrReady), 32'd1);
      step();
      InstrValid = 1'b0;

      // Flush aborts a SAD with counter = 2
      Instr      = I_SAD;
      InstrValid = 1'b1;
      sb_q.push_back(E_SAD);
      step();
      InstrValid = 1'b0;
      step();
      check_busy("sad_f_c1");
      Flush = 1'b1;
      #1;
      check("flush_ready_low", 32'(InstrReady), 32'd0);
      step();
      Flush = 1'b0;
      check("flush_sad_busy",   32'(SadBusy),  32'd0);
      check("flush_sad_ov",     32'(OutValid), 32'd0);
      check("flush_sad_bundle", 32'(w_bundle), 32'd0);
      #1;
      check("flush_sad_ready", 32'(InstrReady), 32'd1);
      step();
      check("flush_sad_idle_busy", 32'(SadBusy), 32'd0);

      // Stall holds a JAL bundle; Stall+Flush squashes it
      Instr      = 32'h0C00_0010;
      InstrValid = 1'b1;
      sb_q.push_back(E_JAL);
      step();
      Instr = I_ADDI;
      Stall = 1'b1;
      #1;
      check("stall_ready", 32'(InstrReady), 32'd0);
      step();
      check("stall1_bundle", 32'(w_bundle), 32'(E_JAL));
      check("stall1_ov",     32'(OutValid), 32'd1);
      step();
      check("stall2_bundle", 32'(w_bundle), 32'(E_JAL));
      Flush = 1'b1;
      step();
      check("stall_flush_ov",     32'(OutValid), 32'd0);
      check("stall_flush_bundle", 32'(w_bundle), 32'd0);
      Stall      = 1'b0;
      Flush      = 1'b0;
      InstrValid = 1'b0;
      step();

      // Illegal opcode
      Instr      = 32'hFC00_0000;
      InstrValid = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      step();
      InstrValid = 1'b0;
      check("ill_trap_ov",   32'(OutValid),  32'd0);
      check("ill_trap_flag", 32'(IllegalOp), 32'd1);
      Flush = 1'b1;
      step();
      Flush = 1'b0;
      check("ill_trap_sticky", 32'(IllegalOp), 32'd1);
`else
      sb_q.push_back(E_ILL);
      step();
      InstrValid = 1'b0;
      check("ill_nop_ov",   32'(OutValid),  32'd1);
      check("ill_nop_flag", 32'(IllegalOp), 32'd0);
`endif

      // Asynchronous reset mid-cycle clears a valid bundle immediately
      Instr      = 32'h8C08_0004;
      InstrValid = 1'b1;
      sb_q.push_back(E_LW);
      step();
      InstrValid = 1'b0;
      Rst        = 1'b1;
      #1;
      check("arst_ov",      32'(OutValid),   32'd0);
      check("arst_bundle",  32'(w_bundle),   32'd0);
      check("arst_illegal", 32'(IllegalOp),  32'd0);
      check("arst_ready",   32'(InstrReady), 32'd0);
      step();
      Rst = 1'b0;
      step();

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
